// File: rtl/pam_pkg.sv
// Shared PAM definitions: legal bits-per-symbol range and the gray-code to
// level-index mapping used by both the transmit mapper and the receive demapper.
package pam_pkg;

    localparam int BPS_MIN = 1;
    localparam int BPS_MAX = 4;

    // Gray code to natural level: each level bit is the XOR of every code bit
    // at or above it, so the MSB passes straight through.
    function automatic logic [BPS_MAX-1:0] gray_to_level(
        input logic [BPS_MAX-1:0] code,
        input int                 bps
    );
        logic [BPS_MAX-1:0] lvl;
        logic               run;
        lvl = '0;
        run = 1'b0;
        for (int i = BPS_MAX - 1; i >= 0; i--) begin
            if (i < bps) begin
                run    = run ^ code[i];
                lvl[i] = run;
            end
        end
        return lvl;
    endfunction

endpackage

// File: rtl/gray2level.sv
// Combinational symbol-bit to PAM level mapping, selectable between gray and
// natural binary.
module gray2level
    import pam_pkg::*;
#(
    parameter int BPS = 2
)(
    input  logic           i_gray_en,
    input  logic [BPS-1:0] i_bits,
    output logic [BPS-1:0] o_level
);

    logic [BPS_MAX-1:0] w_code;
    logic [BPS_MAX-1:0] w_gray;

    assign w_code  = BPS_MAX'(i_bits);
    assign w_gray  = gray_to_level(w_code, BPS);
    assign o_level = i_gray_en ? BPS'(w_gray) : i_bits;

endmodule

// File: rtl/pam_gray_mapper.sv
// Serial bit stream to PAM symbol mapper with a one-entry output register,
// valid/ready handshakes on both sides and zero-padding flush.
module pam_gray_mapper
    import pam_pkg::*;
#(
    parameter int BPS       = 2,
    parameter int MSB_FIRST = 1
)(
    input  logic           clk,
    input  logic           rstn,
    input  logic           data_in,
    input  logic           data_in_valid,
    output logic           data_in_ready,
    input  logic           gray_en,
    input  logic           flush,
    output logic [BPS-1:0] symbol_out,
    output logic           symbol_out_valid,
    input  logic           symbol_out_ready,
    output logic [15:0]    sym_count
);

    localparam int               CNT_W = (BPS > 1) ? $clog2(BPS) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(BPS - 1);

    generate
        if (BPS < BPS_MIN || BPS > BPS_MAX) begin : g_bps_check
            $error("pam_gray_mapper: BPS=%0d outside legal range %0d..%0d",
                   BPS, BPS_MIN, BPS_MAX);
        end
    endgenerate

    logic [BPS-1:0]   r_acc;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             r_flush_pend;
    logic [BPS-1:0]   r_sym;
    logic             r_sym_vld;
    logic [15:0]      r_sym_cnt;

    logic             w_out_free;
    logic             w_sym_xfer;
    logic             w_bit_xfer;
    logic             w_last_bit;
    logic             w_has_bits;
    logic             w_flush_req;
    logic             w_form;
    logic             w_pend_set;
    logic [CNT_W-1:0] w_pos;
    logic [BPS-1:0]   w_acc_nxt;
    logic [BPS-1:0]   w_level;

    assign w_out_free    = !r_sym_vld || symbol_out_ready;
    assign w_sym_xfer    = r_sym_vld && symbol_out_ready;
    // Only the completing bit needs room in the output register; a pending
    // flush owns the accumulator until it has been emitted.
    assign data_in_ready = !r_flush_pend && ((r_bit_cnt != LAST) || w_out_free);

    assign w_bit_xfer  = data_in_valid && data_in_ready;
    assign w_last_bit  = w_bit_xfer && (r_bit_cnt == LAST);
    assign w_has_bits  = w_bit_xfer || (r_bit_cnt != '0);
    assign w_flush_req = flush || r_flush_pend;
    assign w_form      = w_last_bit || (w_flush_req && w_has_bits && w_out_free);
    assign w_pend_set  = flush && w_has_bits && !w_out_free;
    assign w_pos       = (MSB_FIRST != 0) ? (LAST - r_bit_cnt) : r_bit_cnt;

    // Unfilled positions stay zero, which is exactly the flush padding.
    always_comb begin
        w_acc_nxt = r_acc;
        for (int i = 0; i < BPS; i++) begin
            if (w_bit_xfer && (w_pos == CNT_W'(i))) begin
                w_acc_nxt[i] = data_in;
            end
        end
    end

    gray2level #(
        .BPS (BPS)
    ) u_gray2level (
        .i_gray_en (gray_en),
        .i_bits    (w_acc_nxt),
        .o_level   (w_level)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_acc        <= '0;
            r_bit_cnt    <= '0;
            r_flush_pend <= 1'b0;
            r_sym        <= '0;
            r_sym_vld    <= 1'b0;
            r_sym_cnt    <= '0;
        end else begin
            if (w_form) begin
                r_sym        <= w_level;
                r_sym_vld    <= 1'b1;
                r_acc        <= '0;
                r_bit_cnt    <= '0;
                r_flush_pend <= 1'b0;
            end else begin
                if (w_sym_xfer) begin
                    r_sym_vld <= 1'b0;
                end
                r_acc <= w_acc_nxt;
                if (w_bit_xfer) begin
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                end
                if (w_pend_set) begin
                    r_flush_pend <= 1'b1;
                end
            end
            if (w_sym_xfer) begin
                r_sym_cnt <= r_sym_cnt + 16'd1;
            end
        end
    end

    assign symbol_out       = r_sym;
    assign symbol_out_valid = r_sym_vld;
    assign sym_count        = r_sym_cnt;

endmodule
